// File: rtl/bist_pkg.sv
// Shared BIST definitions: checker FSM states and default MISR/test constants.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } bist_state_t;

    localparam int          DEF_WIDTH    = 16;
    localparam logic [15:0] DEF_POLY     = 16'h100B;  // x^16+x^12+x^3+x+1
    localparam logic [15:0] DEF_SEED     = 16'h0000;
    localparam logic [15:0] DEF_GOLDEN   = 16'h0000;

    // Must track the controller's NCLOCK: one capture per controller clock.
    localparam int          BIST_NCLOCK  = 650;
    localparam int          DEF_NCAPTURE = BIST_NCLOCK;

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register with synchronous load and shift controls.
module misr_core #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = 16'h100B,
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] misr,
    output logic [WIDTH-1:0] misr_next
);

    logic [WIDTH-1:0] misr_q;
    logic [WIDTH-1:0] misr_d;

    always_comb begin
        misr_d = misr_q;
        if (load) begin
            misr_d = SEED;
        end else if (shift) begin
            misr_d = {misr_q[WIDTH-2:0], 1'b0}
                   ^ (misr_q[WIDTH-1] ? POLY : '0)
                   ^ din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misr_q <= SEED;
        end else begin
            misr_q <= misr_d;
        end
    end

    assign misr      = misr_q;
    assign misr_next = misr_d;

endmodule

// File: rtl/bist_misr_checker.sv
// BIST output-response analyser: compacts CUT responses, then checks signature
// and capture count against golden values on the controller's finish strobe.
module bist_misr_checker
    import bist_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter logic [WIDTH-1:0] POLY     = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(DEF_SEED),
    parameter logic [WIDTH-1:0] GOLDEN   = WIDTH'(DEF_GOLDEN),
    parameter int               NCAPTURE = DEF_NCAPTURE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             running,
    input  logic             finish,
    input  logic [WIDTH-1:0] cut_out,
    output logic [WIDTH-1:0] signature,
    output logic             sig_valid,
    output logic             pass,
    output logic             fail,
    output logic             proto_err
);

    localparam int CNT_W = $clog2(NCAPTURE + 1) + 1;

    bist_state_t      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sig_valid_q, sig_valid_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             proto_err_q, proto_err_d;
    logic             misr_load, misr_shift;
    logic [WIDTH-1:0] misr_next;

    misr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk       (clk),
        .reset     (reset),
        .load      (misr_load),
        .shift     (misr_shift),
        .din       (cut_out),
        .misr      (signature),
        .misr_next (misr_next)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        sig_valid_d = sig_valid_q;
        pass_d      = pass_q;
        proto_err_d = proto_err_q;
        misr_load   = 1'b0;
        misr_shift  = 1'b0;

        if (init) begin
            misr_load   = 1'b1;
            count_d     = '0;
            sig_valid_d = 1'b0;
            pass_d      = 1'b0;
            state_d     = ST_CAPTURE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (running || finish) proto_err_d = 1'b1;
                end
                ST_CAPTURE: begin
                    if (running) begin
                        misr_shift = 1'b1;
                        if (count_q != '1) count_d = count_q + 1'b1;
                    end
                    // Verdict uses post-step values so a same-cycle capture counts.
                    if (finish) begin
                        state_d     = ST_DONE;
                        sig_valid_d = 1'b1;
                        pass_d      = (misr_next == GOLDEN) &&
                                      (count_d == CNT_W'(NCAPTURE));
                        if (running) proto_err_d = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (running || finish) proto_err_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        fail_d = sig_valid_d & ~pass_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            sig_valid_q <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sig_valid_q <= sig_valid_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign sig_valid = sig_valid_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_bist_misr_checker.sv
// Directed bench: three 8-bit checkers differing only in GOLDEN, plus one default checker.
module tb_bist_misr_checker;
    import bist_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        init = 1'b0, running = 1'b0, finish = 1'b0;
    logic [7:0]  cut_out = 8'h00;
    logic        init16 = 1'b0, run16 = 1'b0, fin16 = 1'b0;
    logic [15:0] cut16 = 16'h0000;
    logic        bist_end = 1'b0;

    logic [7:0]  sig_a, sig_b, sig_c;
    logic        sv_a, pass_a, fail_a, pe_a;
    logic        sv_b, pass_b, fail_b, pe_b;
    logic        sv_c, pass_c, fail_c, pe_c;
    logic [15:0] sig_d;
    logic        sv_d, pass_d, fail_d, pe_d;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bist_misr_checker #(.WIDTH(8), .POLY(8'h1D), .SEED(8'h00), .GOLDEN(8'h1D), .NCAPTURE(2)) u_a (
        .clk(clk), .reset(reset), .init(init), .running(running), .finish(finish),
        .cut_out(cut_out), .signature(sig_a), .sig_valid(sv_a), .pass(pass_a),
        .fail(fail_a), .proto_err(pe_a));

    bist_misr_checker #(.WIDTH(8), .POLY(8'h1D), .SEED(8'h00), .GOLDEN(8'h1C), .NCAPTURE(2)) u_b (
        .clk(clk), .reset(reset), .init(init), .running(running), .finish(finish),
        .cut_out(cut_out), .signature(sig_b), .sig_valid(sv_b), .pass(pass_b),
        .fail(fail_b), .proto_err(pe_b));

    bist_misr_checker #(.WIDTH(8), .POLY(8'h1D), .SEED(8'h00), .GOLDEN(8'h00), .NCAPTURE(2)) u_c (
        .clk(clk), .reset(reset), .init(init), .running(running), .finish(finish),
        .cut_out(cut_out), .signature(sig_c), .sig_valid(sv_c), .pass(pass_c),
        .fail(fail_c), .proto_err(pe_c));

    bist_misr_checker u_d (
        .clk(clk), .reset(reset), .init(init16), .running(run16), .finish(fin16),
        .cut_out(cut16), .signature(sig_d), .sig_valid(sv_d), .pass(pass_d),
        .fail(fail_d), .proto_err(pe_d));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic i, input logic r, input logic f, input logic [7:0] d);
        init = i; running = r; finish = f; cut_out = d;
        @(posedge clk); #1;
        init = 1'b0; running = 1'b0; finish = 1'b0; cut_out = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic run_default(input int ncap);
        init16 = 1'b1;
        @(posedge clk); #1;
        init16 = 1'b0;
        run16  = 1'b1;
        repeat (ncap) begin
            @(posedge clk); #1;
        end
        run16 = 1'b0;
        fin16 = 1'b1;
        @(posedge clk); #1;
        fin16 = 1'b0;
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_sig",   32'(sig_a), 32'h00);
        chk("rst_valid", 32'(sv_a), 32'h0);
        chk("rst_pass",  32'(pass_a), 32'h0);
        chk("rst_fail",  32'(fail_a), 32'h0);
        chk("rst_perr",  32'(pe_a), 32'h0);
        chk("rst_state", 32'(u_a.state_q), 32'(ST_IDLE));
        do_reset();

        // Scenarios 1/2: 80 then 00 -> 80, 1D
        cyc(1, 0, 0, 8'h00);
        chk("s1_sig_after_init", 32'(sig_a), 32'h00);
        cyc(0, 1, 0, 8'h80);
        chk("s1_sig0", 32'(sig_a), 32'h80);
        chk("s1_valid_early", 32'(sv_a), 32'h0);
        cyc(0, 1, 0, 8'h00);
        chk("s1_sig1", 32'(sig_a), 32'h1D);
        cyc(0, 0, 1, 8'h00);
        chk("s1_valid", 32'(sv_a), 32'h1);
        chk("s1_pass",  32'(pass_a), 32'h1);
        chk("s1_fail",  32'(fail_a), 32'h0);
        chk("s2_pass",  32'(pass_b), 32'h0);
        chk("s2_fail",  32'(fail_b), 32'h1);
        chk("s2_perr",  32'(pe_b), 32'h0);
        chk("s1_gold00_fail", 32'(fail_c), 32'h1);
        cyc(0, 0, 0, 8'h00);
        chk("s1_hold_pass", 32'(pass_a), 32'h1);
        chk("s1_hold_sig",  32'(sig_a), 32'h1D);

        // Scenario 3: three captures of 00 -> count mismatch
        cyc(1, 0, 0, 8'h00);
        chk("s3_init_clears_valid", 32'(sv_a), 32'h0);
        repeat (3) cyc(0, 1, 0, 8'h00);
        cyc(0, 0, 1, 8'h00);
        chk("s3_sig",   32'(sig_c), 32'h00);
        chk("s3_valid", 32'(sv_c), 32'h1);
        chk("s3_pass",  32'(pass_c), 32'h0);
        chk("s3_fail",  32'(fail_c), 32'h1);

        // Exactly two captures of 00 -> pass
        cyc(1, 0, 0, 8'h00);
        repeat (2) cyc(0, 1, 0, 8'h00);
        cyc(0, 0, 1, 8'h00);
        chk("s3b_pass", 32'(pass_c), 32'h1);
        chk("s3b_fail", 32'(fail_c), 32'h0);
        chk("s3b_perr", 32'(pe_c), 32'h0);

        // Scenario 4a: running+finish together is compacted and flagged
        do_reset();
        cyc(1, 0, 0, 8'h00);
        cyc(0, 1, 0, 8'h80);
        cyc(0, 1, 1, 8'h00);
        chk("s4a_sig",  32'(sig_a), 32'h1D);
        chk("s4a_pass", 32'(pass_a), 32'h1);
        chk("s4a_perr", 32'(pe_a), 32'h1);

        // Scenario 4b: running in IDLE, proto_err sticky across init
        do_reset();
        chk("s4b_perr_rst", 32'(pe_a), 32'h0);
        cyc(0, 1, 0, 8'hFF);
        chk("s4b_idle_sig",  32'(sig_a), 32'h00);
        chk("s4b_idle_perr", 32'(pe_a), 32'h1);
        cyc(1, 1, 1, 8'hFF);
        chk("s4b_init_over_sig",  32'(sig_a), 32'h00);
        chk("s4b_init_over_valid", 32'(sv_a), 32'h0);
        chk("s4b_perr_after_init", 32'(pe_a), 32'h1);

        // Scenario 4c: activity in DONE is ignored but flagged
        do_reset();
        cyc(1, 0, 0, 8'h00);
        cyc(0, 1, 0, 8'h80);
        cyc(0, 0, 1, 8'h00);
        chk("s4c_fail_count", 32'(fail_a), 32'h1);
        chk("s4c_perr0", 32'(pe_a), 32'h0);
        cyc(0, 1, 0, 8'hFF);
        chk("s4c_done_sig",  32'(sig_a), 32'h80);
        chk("s4c_done_perr", 32'(pe_a), 32'h1);
        chk("s4c_done_fail", 32'(fail_a), 32'h1);
        do_reset();
        chk("s4c_perr_cleared", 32'(pe_a), 32'h0);

        // Scenario 6: asynchronous reset between edges mid-CAPTURE
        cyc(1, 0, 0, 8'h00);
        cyc(0, 1, 0, 8'h55);
        chk("s6_sig_pre", 32'(sig_a), 32'h55);
        #2;
        reset = 1'b0;
        #1;
        chk("s6_async_sig",   32'(sig_a), 32'h00);
        chk("s6_async_state", 32'(u_a.state_q), 32'(ST_IDLE));
        chk("s6_async_valid", 32'(sv_a), 32'h0);
        #1;
        reset = 1'b1;
        cyc(0, 0, 1, 8'h00);
        chk("s6_fin_perr",  32'(pe_a), 32'h1);
        chk("s6_fin_valid", 32'(sv_a), 32'h0);
        chk("s6_fin_sig",   32'(sig_a), 32'h00);

        // Scenario 5: default checker, full 650-capture test
        do_reset();
        run_default(650);
        bist_end = 1'b1;
        chk("s5_valid", 32'(sv_d), 32'h1);
        chk("s5_pass_with_end", 32'(pass_d & bist_end), 32'h1);
        chk("s5_fail", 32'(fail_d), 32'h0);
        chk("s5_sig",  32'(sig_d), 32'h0000);
        chk("s5_perr", 32'(pe_d), 32'h0);
        bist_end = 1'b0;
        init16 = 1'b1;
        @(posedge clk); #1;
        init16 = 1'b0;
        chk("s5_reinit_valid", 32'(sv_d), 32'h0);

        // One capture short of NCAPTURE must fail
        run_default(649);
        chk("s5_short_fail", 32'(fail_d), 32'h1);
        chk("s5_short_pass", 32'(pass_d), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
